// File: rtl/dvs_aer_event_rx.sv
// dvs_aer_event_rx: receives word-serial AER events (Y word, then one or
// more X words) from a DVS sensor. Each event is stamped with the current
// timestamp, held in a small circular buffer and written to a shared FIFO
// bus through a request/grant arbiter.
//
// Sensor handshake: req rises with aer/xsel stable. The block answers with
// ack=1 once the word has been captured. The sensor then drops req, and ack
// falls in the cycle after the synchronised req is seen low.
// FIFO handshake: fifo_req asks for the bus. A grant sampled together with
// fifo_req=1 is answered one cycle later by a single fifo_wr_en pulse that
// carries the head event. fifo_req then stays low for at least one cycle.
//
// Optional feature macro: DVS_AER_BACKPRESSURE_EN. When defined, a full
// buffer stalls the sensor (ack is withheld) instead of dropping events.
module dvs_aer_event_rx #(
    parameter int ADDR_BITS       = 9,
    parameter int TS_BITS         = 32,
    parameter int BUF_DEPTH       = 4,
    parameter int Y_SETTLE_CYCLES = 6,
    localparam int EVENT_BITS     = TS_BITS + 2 * ADDR_BITS + 1,
    localparam int PTR_BITS       = $clog2(BUF_DEPTH),
    localparam int CNT_BITS       = PTR_BITS + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_BITS:0]    aer,
    input  logic                  xsel,
    input  logic                  req,
    input  logic [TS_BITS-1:0]    ts_in,
    input  logic                  fifo_grant,
    output logic                  ack,
    output logic                  fifo_req,
    output logic                  fifo_wr_en,
    output logic [EVENT_BITS-1:0] fifo_event,
    output logic                  overflow,
    output logic [CNT_BITS-1:0]   buf_count
);

    localparam int SET_BITS = $clog2(Y_SETTLE_CYCLES + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETTLE  = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_ACK     = 2'd3;

    localparam logic [1:0] D_IDLE  = 2'd0;
    localparam logic [1:0] D_REQ   = 2'd1;
    localparam logic [1:0] D_GRANT = 2'd2;
    localparam logic [1:0] D_WRITE = 2'd3;

    logic                  req_m;
    logic                  req_s;
    logic [1:0]            cap_state;
    logic [1:0]            drn_state;
    logic [SET_BITS-1:0]   settle_cnt;
    logic [ADDR_BITS-1:0]  y_reg;
    logic                  y_valid;
    logic [PTR_BITS-1:0]   wr_ptr;
    logic [PTR_BITS-1:0]   rd_ptr;
    logic [EVENT_BITS-1:0] mem [BUF_DEPTH];
    logic [EVENT_BITS-1:0] new_event;
    logic                  push_req;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  stall;

    // Two-flop synchroniser for the asynchronous sensor request.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_m <= 1'b0;
            req_s <= 1'b0;
        end else begin
            req_m <= req;
            req_s <= req_m;
        end
    end

    // Push/pop decisions and the event word assembled in the capture cycle.
    always_comb begin
        new_event = {ts_in, aer[ADDR_BITS:1], y_reg, aer[0]};
        full      = (buf_count == CNT_BITS'(BUF_DEPTH));
        pop       = (drn_state == D_GRANT);
        push_req  = (cap_state == S_CAPTURE) && xsel && y_valid;
        push      = push_req && (!full || pop);
`ifdef DVS_AER_BACKPRESSURE_EN
        stall     = push_req && full && !pop;
`else
        stall     = 1'b0;
`endif
    end

    // Capture FSM: settle wait for Y words, capture, then hold ack until req drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_state  <= S_IDLE;
            settle_cnt <= '0;
            ack        <= 1'b0;
            y_reg      <= '0;
            y_valid    <= 1'b0;
        end else begin
            case (cap_state)
                S_IDLE: begin
                    if (req_s) begin
                        if (xsel) begin
                            cap_state <= S_CAPTURE;
                        end else begin
                            cap_state  <= S_SETTLE;
                            settle_cnt <= '0;
                        end
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == SET_BITS'(Y_SETTLE_CYCLES - 1)) begin
                        cap_state <= S_CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt + SET_BITS'(1);
                    end
                end
                S_CAPTURE: begin
                    if (!stall) begin
                        cap_state <= S_ACK;
                        ack       <= 1'b1;
                        if (!xsel) begin
                            y_reg   <= aer[ADDR_BITS-1:0];
                            y_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (!req_s) begin
                        cap_state <= S_IDLE;
                        ack       <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Buffer storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_event;
        end
    end

    // Buffer pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_BITS'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            end
            case ({push, pop})
                2'b10:   buf_count <= buf_count + CNT_BITS'(1);
                2'b01:   buf_count <= buf_count - CNT_BITS'(1);
                default: buf_count <= buf_count;
            endcase
`ifdef DVS_AER_BACKPRESSURE_EN
            overflow <= 1'b0;
`else
            if (push_req && !push) begin
                overflow <= 1'b1;
            end
`endif
        end
    end

    // Drain FSM: request the bus, write the head one cycle after the grant, then back off.
    always_ff @(posedge clk) begin
        if (rst) begin
            drn_state  <= D_IDLE;
            fifo_req   <= 1'b0;
            fifo_wr_en <= 1'b0;
            fifo_event <= '0;
        end else begin
            case (drn_state)
                D_IDLE: begin
                    if (buf_count != '0) begin
                        drn_state <= D_REQ;
                        fifo_req  <= 1'b1;
                    end
                end
                D_REQ: begin
                    if (fifo_grant) begin
                        drn_state <= D_GRANT;
                    end
                end
                D_GRANT: begin
                    drn_state  <= D_WRITE;
                    fifo_req   <= 1'b0;
                    fifo_wr_en <= 1'b1;
                    fifo_event <= mem[rd_ptr];
                end
                default: begin
                    drn_state  <= D_IDLE;
                    fifo_wr_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
